fco_align_ctrl: RTL and testbench
=================================

// Module: fco_align_ctrl
// PURPOSE
//  Parametrised frame-clock bitslip controller for multi-lane ADC ISERDES capture.
//  Slips all lanes together until the deserialised FCO word equals PATTERN for VERIFY_CNT
//  consecutive samples, then keeps monitoring. On loss of lock it raises a flag and can
//  realign automatically. It gives up with an error after MAX_SLIPS slips.
// PARAMETERS
//  WIDTH          8       ISERDES deserialisation factor (FCO word width)
//  PATTERN        8'hF0   expected FCO word when aligned (WIDTH bits)
//  N_LANES        4       data lanes receiving the broadcast bitslip (FCO lane included)
//  STARTUP_CYCLES 8       CE-qualified cycles to wait after reset before the first check
//  SETTLE_CYCLES  8       cycles to wait after each slip before sampling FCO again
//  VERIFY_CNT     4       consecutive matches needed to declare lock
//  LOSS_CNT       4       consecutive mismatches in LOCKED that declare loss of lock
//  MAX_SLIPS      2*WIDTH slips per attempt before FAIL
//  AUTO_RELOCK    1       1: loss of lock re-enters CHECK; 0: stay LOCKED and flag only
// PORTS
//  CLKDIV         in   1               divided ISERDES clock; all logic on posedge
//  rst_n          in   1               synchronous reset, active low
//  CE             in   1               startup-count enable
//  realign        in   1               one-cycle request to restart alignment
//  ISERDES_FCO    in   WIDTH           deserialised frame-clock word
//  ISERDES_bslip  out  N_LANES         bitslip pulse, identical on all bits
//  aligned        out  1               high while in LOCKED
//  align_err      out  1               high while in FAIL
//  lock_lost      out  1               sticky: loss of lock seen since last realign/reset
//  slip_count     out  $clog2(MAX_SLIPS+1)  slips issued in the current attempt
// BEHAVIOUR
//  - All outputs are registered. While rst_n=0 (sampled): state=STARTUP, all outputs 0, all counters 0.
//    Reset mid-operation aborts immediately, including during SLIP/SETTLE.
//  - STARTUP: counter increments when CE=1. The cycle it reaches STARTUP_CYCLES-1 with CE=1 -> CHECK.
//  - CHECK: sample ISERDES_FCO every cycle.
//    Match: match_cnt++. When it reaches VERIFY_CNT -> LOCKED, with aligned=1 on the next cycle.
//    Mismatch: if slip_count==MAX_SLIPS -> FAIL; else -> SLIP.
//  - SLIP: ISERDES_bslip='1 for exactly one cycle; slip_count++ (saturates at MAX_SLIPS); -> SETTLE.
//  - SETTLE: wait SETTLE_CYCLES cycles, then clear match_cnt and -> CHECK.
//    Minimum spacing between bslip pulses = SETTLE_CYCLES+2 cycles.
//  - LOCKED: aligned=1. Consecutive-mismatch counter resets on any match.
//    When it reaches LOSS_CNT: lock_lost<=1. If AUTO_RELOCK: clear slip_count and match_cnt,
//    aligned<=0, -> CHECK. Otherwise stay LOCKED.
//  - FAIL: align_err=1, no further slips. Leaves only via realign or reset.
//  - realign=1 in LOCKED or FAIL: clear slip_count, match_cnt and lock_lost, -> CHECK.
//    Ignored in STARTUP/SLIP/SETTLE/CHECK.
//    Same cycle as a loss-of-lock event: realign wins and lock_lost stays 0.
//  - Mismatch in CHECK that would be slip MAX_SLIPS+1 -> FAIL without pulsing bslip.
//  - Illegal state encoding -> STARTUP on the next cycle.
// STRUCTURE
//  - bitslip_pkg: state enum (STARTUP, CHECK, SLIP, SETTLE, LOCKED, FAIL, one-hot, logic [5:0])
//    and a parameter-free helper function cnt_w(n)=$clog2(n+1).
//  - One sub-module, tick_counter #(MAX): a loadable up-counter with enable, clear and a done flag,
//    reused for the startup, settle, match and loss counts.
//  - Two-process FSM: state register plus combinational next-state; outputs registered from next-state.
// TESTING
//  1 Reset: hold rst_n=0 for 5 cycles with FCO=8'h0F -> all outputs 0, no bslip.
//    Release with CE=1 -> first FCO compare occurs on cycle 8.
//  2 Aligned after 3 slips: model rotates FCO one bit per bslip, starting at 8'h1E ->
//    exactly 3 single-cycle pulses spaced >=10 cycles; slip_count=3;
//    aligned rises 4 match cycles after the last settle; ISERDES_bslip=4'hF on each pulse.
//  3 Never aligns: FCO stuck at 8'hAA -> 16 pulses, then align_err=1, slip_count=16,
//    no 17th pulse; realign=1 -> align_err=0, slip_count=0, slipping resumes.
//  4 Loss of lock: after lock, corrupt FCO for 3 cycles -> aligned stays 1;
//    for 4 cycles -> lock_lost=1, aligned=0, CHECK re-entered, relock with slip_count reset.
//  5 AUTO_RELOCK=0, WIDTH=10, PATTERN=10'h3E0: loss event -> lock_lost=1, aligned stays 1, no bslip.
//  6 Simultaneous realign and 4th mismatch in LOCKED -> lock_lost=0, CHECK entered.
//    rst_n=0 during SETTLE -> STARTUP, and no pending bslip pulse follows.

Source files
------------

// File: rtl/bitslip_pkg.sv
// Shared types and helpers for the FCO bitslip alignment controller.
// One-hot state encoding and counter width helper.
package bitslip_pkg;

    typedef enum logic [5:0] {
        ST_STARTUP = 6'b000001,
        ST_CHECK   = 6'b000010,
        ST_SLIP    = 6'b000100,
        ST_SETTLE  = 6'b001000,
        ST_LOCKED  = 6'b010000,
        ST_FAIL    = 6'b100000
    } state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Saturating up-counter with clear, load and terminal-count flag.
// done is high while count sits at MAX-1.
module tick_counter
    import bitslip_pkg::*;
#(
    parameter int MAX = 8,
    parameter int W   = cnt_w(MAX)
) (
    input  logic         CLKDIV,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge CLKDIV) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != W'(MAX)) begin
            count <= count + W'(1);
        end
    end

    assign done = (count == W'(MAX - 1));

endmodule

// File: rtl/fco_align_ctrl.sv
// Frame-clock bitslip controller: slips all lanes until the FCO word
// matches PATTERN, then monitors for loss of lock.
module fco_align_ctrl
    import bitslip_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter logic [WIDTH-1:0] PATTERN        = 8'hF0,
    parameter int               N_LANES        = 4,
    parameter int               STARTUP_CYCLES = 8,
    parameter int               SETTLE_CYCLES  = 8,
    parameter int               VERIFY_CNT     = 4,
    parameter int               LOSS_CNT       = 4,
    parameter int               MAX_SLIPS      = 2 * WIDTH,
    parameter bit               AUTO_RELOCK    = 1'b1,
    parameter int               SW             = cnt_w(MAX_SLIPS)
) (
    input  logic               CLKDIV,
    input  logic               rst_n,
    input  logic               CE,
    input  logic               realign,
    input  logic [WIDTH-1:0]   ISERDES_FCO,
    output logic [N_LANES-1:0] ISERDES_bslip,
    output logic               aligned,
    output logic               align_err,
    output logic               lock_lost,
    output logic [SW-1:0]      slip_count
);

    localparam int SUW = cnt_w(STARTUP_CYCLES);
    localparam int STW = cnt_w(SETTLE_CYCLES);
    localparam int MTW = cnt_w(VERIFY_CNT);
    localparam int LSW = cnt_w(LOSS_CNT);

    state_t         state;
    state_t         nxt;
    logic           match;
    logic           relock;
    logic           loss;
    logic           su_done;
    logic           st_done;
    logic           mt_done;
    logic           ls_done;
    logic           sl_done;
    logic [SUW-1:0] su_cnt;
    logic [STW-1:0] st_cnt;
    logic [MTW-1:0] mt_cnt;
    logic [LSW-1:0] ls_cnt;
    logic           unused_cnt;

    assign match  = (ISERDES_FCO == PATTERN);
    assign relock = realign && (state == ST_LOCKED || state == ST_FAIL);
    assign loss   = (state == ST_LOCKED) && !match && ls_done;

    assign unused_cnt = ^{su_cnt, st_cnt, mt_cnt, ls_cnt, sl_done};

    tick_counter #(.MAX(STARTUP_CYCLES), .W(SUW)) u_startup (
        .CLKDIV   (CLKDIV),
        .rst_n    (rst_n),
        .clr      (state != ST_STARTUP),
        .load     (1'b0),
        .load_val ('0),
        .en       (state == ST_STARTUP && CE),
        .count    (su_cnt),
        .done     (su_done)
    );

    tick_counter #(.MAX(SETTLE_CYCLES), .W(STW)) u_settle (
        .CLKDIV   (CLKDIV),
        .rst_n    (rst_n),
        .clr      (state != ST_SETTLE),
        .load     (1'b0),
        .load_val ('0),
        .en       (state == ST_SETTLE),
        .count    (st_cnt),
        .done     (st_done)
    );

    // Any exit from CHECK discards the partial match run.
    tick_counter #(.MAX(VERIFY_CNT), .W(MTW)) u_match (
        .CLKDIV   (CLKDIV),
        .rst_n    (rst_n),
        .clr      (state != ST_CHECK),
        .load     (1'b0),
        .load_val ('0),
        .en       (state == ST_CHECK && match),
        .count    (mt_cnt),
        .done     (mt_done)
    );

    tick_counter #(.MAX(LOSS_CNT), .W(LSW)) u_loss (
        .CLKDIV   (CLKDIV),
        .rst_n    (rst_n),
        .clr      (state != ST_LOCKED || match),
        .load     (1'b0),
        .load_val ('0),
        .en       (state == ST_LOCKED && !match),
        .count    (ls_cnt),
        .done     (ls_done)
    );

    tick_counter #(.MAX(MAX_SLIPS), .W(SW)) u_slip (
        .CLKDIV   (CLKDIV),
        .rst_n    (rst_n),
        .clr      (relock || (loss && AUTO_RELOCK)),
        .load     (1'b0),
        .load_val ('0),
        .en       (nxt == ST_SLIP),
        .count    (slip_count),
        .done     (sl_done)
    );

    always_ff @(posedge CLKDIV) begin
        if (!rst_n) begin
            state <= ST_STARTUP;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (1'b1)
            (state == ST_STARTUP): begin
                if (CE && su_done) nxt = ST_CHECK;
            end
            (state == ST_CHECK): begin
                if (match) begin
                    if (mt_done) nxt = ST_LOCKED;
                end else if (slip_count == SW'(MAX_SLIPS)) begin
                    nxt = ST_FAIL;
                end else begin
                    nxt = ST_SLIP;
                end
            end
            (state == ST_SLIP): begin
                nxt = ST_SETTLE;
            end
            (state == ST_SETTLE): begin
                if (st_done) nxt = ST_CHECK;
            end
            (state == ST_LOCKED): begin
                if (relock || (loss && AUTO_RELOCK)) nxt = ST_CHECK;
            end
            (state == ST_FAIL): begin
                if (relock) nxt = ST_CHECK;
            end
            default: begin
                nxt = ST_STARTUP;
            end
        endcase
    end

    // Outputs follow the next state so they line up with the state register.
    always_ff @(posedge CLKDIV) begin
        if (!rst_n) begin
            ISERDES_bslip <= '0;
            aligned       <= 1'b0;
            align_err     <= 1'b0;
            lock_lost     <= 1'b0;
        end else begin
            ISERDES_bslip <= {N_LANES{nxt == ST_SLIP}};
            aligned       <= (nxt == ST_LOCKED);
            align_err     <= (nxt == ST_FAIL);
            if (relock) begin
                lock_lost <= 1'b0;
            end else if (loss) begin
                lock_lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fco_align_ctrl.sv
// Directed bench for fco_align_ctrl with a rotating FCO model
// and a queue of expected slip counts per bitslip pulse.
module tb_fco_align_ctrl;

    logic CLKDIV = 1'b0;
    always #5 CLKDIV = ~CLKDIV;

    logic       rst_n;
    logic       CE;
    logic       realign;
    logic [7:0] fco;
    logic [3:0] bslip;
    logic       aligned;
    logic       align_err;
    logic       lock_lost;
    logic [4:0] slip_count;

    logic       rst2_n;
    logic       realign2 = 1'b0;
    logic [9:0] fco2;
    logic [3:0] bslip2;
    logic       aligned2;
    logic       align_err2;
    logic       lock_lost2;
    logic [4:0] slip_count2;

    logic       ld;
    logic [7:0] ld_val;
    logic       ovr_en;
    logic [7:0] ovr;
    logic [7:0] fco_rot;

    int checks     = 0;
    int errors     = 0;
    int pulses     = 0;
    int pulses2    = 0;
    int cyc        = 0;
    int last_pulse = -1;
    int exp_q[$];

    fco_align_ctrl dut (
        .CLKDIV        (CLKDIV),
        .rst_n         (rst_n),
        .CE            (CE),
        .realign       (realign),
        .ISERDES_FCO   (fco),
        .ISERDES_bslip (bslip),
        .aligned       (aligned),
        .align_err     (align_err),
        .lock_lost     (lock_lost),
        .slip_count    (slip_count)
    );

    fco_align_ctrl #(
        .WIDTH       (10),
        .PATTERN     (10'h3E0),
        .AUTO_RELOCK (1'b0)
    ) dut2 (
        .CLKDIV        (CLKDIV),
        .rst_n         (rst2_n),
        .CE            (CE),
        .realign       (realign2),
        .ISERDES_FCO   (fco2),
        .ISERDES_bslip (bslip2),
        .aligned       (aligned2),
        .align_err     (align_err2),
        .lock_lost     (lock_lost2),
        .slip_count    (slip_count2)
    );

    // ISERDES model: each bitslip rotates the captured word by one bit.
    always @(posedge CLKDIV) begin
        cyc <= cyc + 1;
        if (ld) begin
            fco_rot <= ld_val;
        end else if (bslip[0]) begin
            fco_rot <= {fco_rot[6:0], fco_rot[7]};
        end
    end

    assign fco = ovr_en ? ovr : fco_rot;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLKDIV) begin
        if (bslip !== '0) begin
            int e;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            chk("bslip_all_lanes", 32'(bslip), 32'hF);
            chk("bslip_slip_count", 32'(slip_count), e);
            if (last_pulse >= 0) begin
                chk("bslip_spacing", 32'(cyc - last_pulse >= 10), 1);
            end
            last_pulse = cyc;
            pulses++;
        end
        if (bslip2 !== '0) pulses2++;
    end

    initial begin
        int n;
        int p0;
        rst_n   = 1'b0;
        rst2_n  = 1'b0;
        CE      = 1'b1;
        realign = 1'b0;
        ovr_en  = 1'b1;
        ovr     = 8'h0F;
        ld      = 1'b0;
        ld_val  = 8'h00;
        fco2    = 10'h3E0;

        // reset values and first compare latency
        repeat (5) @(negedge CLKDIV);
        chk("rst_bslip", 32'(bslip), 0);
        chk("rst_aligned", 32'(aligned), 0);
        chk("rst_align_err", 32'(align_err), 0);
        chk("rst_lock_lost", 32'(lock_lost), 0);
        chk("rst_slip_count", 32'(slip_count), 0);
        exp_q.push_back(1);
        rst_n = 1'b1;
        n = 0;
        while (bslip === '0 && n < 40) begin
            @(negedge CLKDIV);
            n++;
        end
        chk("t1_first_cmp", n, 9);

        // align after three slips from 8'h1E
        rst_n  = 1'b0;
        ovr_en = 1'b0;
        ld     = 1'b1;
        ld_val = 8'h1E;
        repeat (2) @(negedge CLKDIV);
        ld = 1'b0;
        for (int i = 1; i <= 3; i++) exp_q.push_back(i);
        p0 = pulses;
        rst_n = 1'b1;
        n = 0;
        while (aligned !== 1'b1 && n < 200) begin
            @(negedge CLKDIV);
            n++;
        end
        chk("t2_aligned", 32'(aligned), 1);
        chk("t2_slip_count", 32'(slip_count), 3);
        chk("t2_pulses", pulses - p0, 3);
        chk("t2_lock_delay", cyc - last_pulse, 13);
        chk("t2_queue_drained", exp_q.size(), 0);

        // short glitch keeps lock, long glitch loses it
        repeat (2) @(negedge CLKDIV);
        ovr    = 8'h00;
        ovr_en = 1'b1;
        repeat (3) @(negedge CLKDIV);
        chk("t4_glitch_aligned", 32'(aligned), 1);
        ovr_en = 1'b0;
        repeat (3) @(negedge CLKDIV);
        chk("t4_glitch_no_loss", 32'(lock_lost), 0);
        chk("t4_glitch_still", 32'(aligned), 1);
        ovr_en = 1'b1;
        repeat (4) @(negedge CLKDIV);
        ovr_en = 1'b0;
        chk("t4_loss_flag", 32'(lock_lost), 1);
        chk("t4_loss_unaligned", 32'(aligned), 0);
        chk("t4_loss_slip_clr", 32'(slip_count), 0);
        n = 0;
        while (aligned !== 1'b1 && n < 20) begin
            @(negedge CLKDIV);
            n++;
        end
        chk("t4_relock_lat", n, 4);
        chk("t4_relock_slips", 32'(slip_count), 0);
        chk("t4_lost_sticky", 32'(lock_lost), 1);

        // realign on the same cycle as the loss event wins
        repeat (2) @(negedge CLKDIV);
        ovr_en = 1'b1;
        repeat (3) @(negedge CLKDIV);
        realign = 1'b1;
        @(negedge CLKDIV);
        realign = 1'b0;
        ovr_en  = 1'b0;
        chk("t6_realign_lost", 32'(lock_lost), 0);
        chk("t6_realign_unaligned", 32'(aligned), 0);
        n = 0;
        while (aligned !== 1'b1 && n < 20) begin
            @(negedge CLKDIV);
            n++;
        end
        chk("t6_relock_lat", n, 4);
        chk("t6_lost_clear", 32'(lock_lost), 0);

        // never aligns: 16 slips then FAIL, realign resumes
        rst_n  = 1'b0;
        ovr    = 8'hAA;
        ovr_en = 1'b1;
        repeat (2) @(negedge CLKDIV);
        for (int i = 1; i <= 16; i++) exp_q.push_back(i);
        p0 = pulses;
        rst_n = 1'b1;
        n = 0;
        while (align_err !== 1'b1 && n < 400) begin
            @(negedge CLKDIV);
            n++;
        end
        chk("t3_align_err", 32'(align_err), 1);
        chk("t3_slip_count", 32'(slip_count), 16);
        chk("t3_pulses", pulses - p0, 16);
        repeat (30) @(negedge CLKDIV);
        chk("t3_no_17th", pulses - p0, 16);
        chk("t3_err_held", 32'(align_err), 1);
        exp_q.push_back(1);
        realign = 1'b1;
        @(negedge CLKDIV);
        realign = 1'b0;
        chk("t3_err_clr", 32'(align_err), 0);
        chk("t3_slip_clr", 32'(slip_count), 0);
        @(negedge CLKDIV);
        chk("t3_resume_pulse", 32'(bslip), 32'hF);

        // reset during SETTLE, then CE gates the startup count
        repeat (3) @(negedge CLKDIV);
        rst_n = 1'b0;
        CE    = 1'b0;
        repeat (2) @(negedge CLKDIV);
        chk("t6_rst_slip_count", 32'(slip_count), 0);
        chk("t6_rst_bslip", 32'(bslip), 0);
        p0 = pulses;
        rst_n = 1'b1;
        repeat (20) @(negedge CLKDIV);
        chk("t6_ce_hold", pulses - p0, 0);
        exp_q.push_back(1);
        CE = 1'b1;
        n = 0;
        while (bslip === '0 && n < 40) begin
            @(negedge CLKDIV);
            n++;
        end
        chk("t6_ce_start_lat", n, 9);
        rst_n = 1'b0;

        // no auto relock, 10-bit pattern
        rst2_n = 1'b1;
        n = 0;
        while (aligned2 !== 1'b1 && n < 40) begin
            @(negedge CLKDIV);
            n++;
        end
        chk("t5_lock_lat", n, 12);
        fco2 = 10'h000;
        repeat (4) @(negedge CLKDIV);
        fco2 = 10'h3E0;
        chk("t5_lost", 32'(lock_lost2), 1);
        chk("t5_still_aligned", 32'(aligned2), 1);
        repeat (6) @(negedge CLKDIV);
        chk("t5_aligned_hold", 32'(aligned2), 1);
        chk("t5_lost_sticky", 32'(lock_lost2), 1);
        chk("t5_no_err", 32'(align_err2), 0);
        chk("t5_slip_count", 32'(slip_count2), 0);
        chk("t5_no_bslip", pulses2, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
